// File: rtl/imm_gen_pipe_if.sv
// imm_gen_pipe_if: instruction-in / immediate-out valid-ready bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_type;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;
  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );
  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_type, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator behind a 2-entry skid buffer; IMMGEN_CSR_UIMM_EN adds CSR uimm decode
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  imm_gen_pipe_if.slave      bus,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] illegal_count
);
  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       typ;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } ent_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  localparam bit RV64 = (XLEN == 64);
  state_t      state, state_nx;
  ent_t        main_q, skid_q, dec;
  logic [31:0] ins;
  logic        acc, pop, ld_main, ld_skid, mv;
  assign ins = bus.in_instr;
  always_comb begin
    dec = '0;
    dec.tag = bus.in_tag;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec.typ = 3'd1;
        dec.imm = XLEN'($signed(ins[31:20]));
      end
      7'b0011011: begin
        dec.typ = RV64 ? 3'd1 : 3'd0;
        dec.imm = RV64 ? XLEN'($signed(ins[31:20])) : '0;
        dec.ill = !RV64;
      end
      7'b0100011: begin
        dec.typ = 3'd2;
        dec.imm = XLEN'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        dec.typ = 3'd3;
        dec.imm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec.typ = 3'd4;
        dec.imm = XLEN'($signed({ins[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.typ = 3'd5;
        dec.imm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'b0110011, 7'b0001111: dec.ill = 1'b0;
      7'b1110011: begin
`ifdef IMMGEN_CSR_UIMM_EN
        dec.typ = ins[14] ? 3'd6 : 3'd0;
        dec.imm = ins[14] ? XLEN'(ins[19:15]) : '0;
`else
        dec.ill = 1'b0;
`endif
      end
      7'b0111011: dec.ill = !RV64;
      default: dec.ill = 1'b1;
    endcase
  end
  assign bus.in_ready    = (state != FULL) && !reset;
  assign bus.out_valid   = (state != EMPTY);
  assign bus.out_imm     = main_q.imm;
  assign bus.out_type    = main_q.typ;
  assign bus.out_illegal = main_q.ill;
  assign bus.out_tag     = main_q.tag;
  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  always_comb begin
    state_nx = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    mv       = 1'b0;
    case (state)
      EMPTY: begin
        state_nx = acc ? ONE : EMPTY;
        ld_main  = acc;
      end
      ONE: begin
        ld_main  = acc && pop;
        ld_skid  = acc && !pop;
        state_nx = (acc && !pop) ? FULL : (pop && !acc) ? EMPTY : ONE;
      end
      FULL: begin
        state_nx = pop ? ONE : FULL;
        mv       = pop;
      end
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= EMPTY;
      main_q        <= '0;
      skid_q        <= '0;
      illegal_count <= '0;
    end else begin
      state <= state_nx;
      if (ld_main) main_q <= dec;
      else if (mv) main_q <= skid_q;
      if (ld_skid) skid_q <= dec;
      else if (mv) skid_q <= '0;
      if (cnt_clr) illegal_count <= '0;
      else if (acc && dec.ill && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: drives RV32, RV64 and 2-bit-counter instances in lockstep against a FIFO/decode reference model
module tb_imm_gen_pipe;
  typedef struct { logic [31:0] ins; logic [7:0] tag; } ent_t;
  typedef struct { longint imm; int typ; bit ill; } dec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic [15:0] cnt32, cnt64;
  logic [1:0]  cntsat;
  int checks = 0;
  int errors = 0;
  ent_t mq[$];
  int c32 = 0, c64 = 0, csat = 0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) i32 ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) i64 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) isat ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .COUNT_W(16)) u32 (
    .clk(clk), .reset(rst), .bus(i32.slave), .cnt_clr(clr), .illegal_count(cnt32));
  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .COUNT_W(16)) u64 (
    .clk(clk), .reset(rst), .bus(i64.slave), .cnt_clr(clr), .illegal_count(cnt64));
  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .COUNT_W(2)) usat (
    .clk(clk), .reset(rst), .bus(isat.slave), .cnt_clr(clr), .illegal_count(cntsat));

  function automatic dec_t dec(input logic [31:0] i, input bit rv64);
    dec_t d;
    logic [6:0] op;
    d = '{0, 0, 1'b0};
    op = i[6:0];
    if (op inside {7'h03, 7'h13, 7'h67} || (rv64 && op == 7'h1B)) begin
      d.typ = 1; d.imm = $signed(i[31:20]);
    end else if (op == 7'h23) begin
      d.typ = 2; d.imm = $signed({i[31:25], i[11:7]});
    end else if (op == 7'h63) begin
      d.typ = 3; d.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
    end else if (op inside {7'h37, 7'h17}) begin
      d.typ = 4; d.imm = $signed({i[31:12], 12'h000});
    end else if (op == 7'h6F) begin
      d.typ = 5; d.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
    end else if (op inside {7'h33, 7'h0F} || (rv64 && op == 7'h3B)) begin
      d.typ = 0;
    end else if (op == 7'h73) begin
`ifdef IMMGEN_CSR_UIMM_EN
      if (i[14]) begin d.typ = 6; d.imm = longint'(i[19:15]); end
`endif
    end else begin
      d.ill = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] rnd_ins();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 15);
    case (k)
      0: r[6:0] = 7'h03;  1: r[6:0] = 7'h13;  2: r[6:0] = 7'h67;  3: r[6:0] = 7'h1B;
      4: r[6:0] = 7'h23;  5: r[6:0] = 7'h63;  6: r[6:0] = 7'h6F;  7: r[6:0] = 7'h37;
      8: r[6:0] = 7'h17;  9: r[6:0] = 7'h33;  10: r[6:0] = 7'h0F; 11: r[6:0] = 7'h73;
      12: r[6:0] = 7'h3B; default: r[6:0] = r[6:0];
    endcase
    if ($urandom_range(0, 15) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    dec_t a, b;
    logic mr;
    longint ai;
    mr = !rst && mq.size() < 2;
    chk("rdy32", 64'(i32.in_ready), 64'(mr));
    chk("rdy64", 64'(i64.in_ready), 64'(mr));
    chk("rdysat", 64'(isat.in_ready), 64'(mr));
    chk("vld32", 64'(i32.out_valid), 64'(mq.size() != 0));
    chk("vld64", 64'(i64.out_valid), 64'(mq.size() != 0));
    chk("cnt32", 64'(cnt32), 64'(c32));
    chk("cnt64", 64'(cnt64), 64'(c64));
    chk("cntsat", 64'(cntsat), 64'(csat));
    if (mq.size() != 0) begin
      a = dec(mq[0].ins, 1'b0);
      b = dec(mq[0].ins, 1'b1);
      ai = a.imm;
      chk("imm32", 64'(i32.out_imm), 64'(ai[31:0]));
      chk("type32", 64'(i32.out_type), 64'(a.typ));
      chk("ill32", 64'(i32.out_illegal), 64'(a.ill));
      chk("tag32", 64'(i32.out_tag), 64'(mq[0].tag));
      chk("imm64", i64.out_imm, b.imm);
      chk("type64", 64'(i64.out_type), 64'(b.typ));
      chk("ill64", 64'(i64.out_illegal), 64'(b.ill));
      chk("tag64", 64'(i64.out_tag), 64'(mq[0].tag));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with the model advanced.
  task automatic step(input logic r, input logic v, input logic [31:0] i, input logic [7:0] t,
                      input logic o, input logic c);
    logic acc, pop;
    rst = r; clr = c;
    i32.in_valid = v;  i64.in_valid = v;  isat.in_valid = v;
    i32.in_instr = i;  i64.in_instr = i;  isat.in_instr = i;
    i32.in_tag = t;    i64.in_tag = t;    isat.in_tag = t;
    i32.out_ready = o; i64.out_ready = o; isat.out_ready = o;
    #1;
    check_all();
    acc = v && !r && mq.size() < 2;
    pop = o && mq.size() != 0;
    @(posedge clk);
    if (r) begin
      mq.delete();
      c32 = 0; c64 = 0; csat = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) mq.push_back('{i, t});
      if (c) begin
        c32 = 0; c64 = 0; csat = 0;
      end else if (acc) begin
        if (dec(i, 1'b0).ill) begin
          c32 = (c32 == 65535) ? c32 : c32 + 1;
          csat = (csat == 3) ? csat : csat + 1;
        end
        if (dec(i, 1'b1).ill) c64 = (c64 == 65535) ? c64 : c64 + 1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    i32.in_valid = 0;  i64.in_valid = 0;  isat.in_valid = 0;
    i32.in_instr = 0;  i64.in_instr = 0;  isat.in_instr = 0;
    i32.in_tag = 0;    i64.in_tag = 0;    isat.in_tag = 0;
    i32.out_ready = 0; i64.out_ready = 0; isat.out_ready = 0;
    @(negedge clk);
    step(1, 1, 32'h0000_0013, 8'h00, 0, 0);
    step(1, 1, 32'h0000_0013, 8'h00, 0, 0);
    chk("rst_rdy", 64'(i32.in_ready), 64'(0));
    chk("rst_imm", i64.out_imm, 64'(0));
    chk("rst_type", 64'(i32.out_type), 64'(0));
    chk("rst_ill", 64'(i32.out_illegal), 64'(0));
    chk("rst_tag", 64'(i32.out_tag), 64'(0));
    step(0, 1, 32'hFFC1_2083, 8'h01, 1, 0);
    chk("lw_imm", 64'(i32.out_imm), 64'h0000_0000_FFFF_FFFC);
    chk("lw_type", 64'(i32.out_type), 64'(1));
    step(0, 1, 32'h0051_2423, 8'h02, 1, 0);
    chk("sw_imm", 64'(i32.out_imm), 64'h0000_0000_0000_0008);
    chk("sw_type", 64'(i32.out_type), 64'(2));
    step(0, 1, 32'hFE00_0EE3, 8'h03, 1, 0);
    chk("beq_imm", 64'(i32.out_imm), 64'h0000_0000_FFFF_FFFC);
    chk("beq_tag", 64'(i32.out_tag), 64'h03);
    step(0, 1, 32'h8000_00B7, 8'h04, 1, 0);
    chk("lui64_imm", i64.out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui64_type", 64'(i64.out_type), 64'(4));
    step(0, 1, 32'h0010_0093, 8'h10, 0, 0);
    step(0, 1, 32'h0020_0113, 8'h11, 0, 0);
    chk("full_rdy", 64'(i32.in_ready), 64'(0));
    step(0, 1, 32'h0030_0193, 8'h12, 0, 0);
    step(0, 1, 32'h0030_0193, 8'h12, 1, 0);
    step(0, 1, 32'h0030_0193, 8'h12, 1, 0);
    step(0, 0, 32'h0, 8'h00, 1, 0);
    step(0, 0, 32'h0, 8'h00, 1, 1);
    step(0, 1, 32'h0, 8'h20, 1, 0);
    chk("ill_a", 64'(i32.out_illegal), 64'(1));
    chk("cnt_1", 64'(cnt32), 64'(1));
    step(0, 1, 32'h0, 8'h21, 1, 0);
    chk("cnt_2", 64'(cnt32), 64'(2));
    step(0, 1, 32'h0, 8'h22, 1, 1);
    chk("ill_c", 64'(i32.out_illegal), 64'(1));
    chk("cnt_clr", 64'(cnt32), 64'(0));
    for (int n = 0; n < 5; n++) step(0, 1, 32'h0, 8'(n), 1, 0);
    chk("cnt_sat", 64'(cntsat), 64'(3));
    chk("cnt_5", 64'(cnt32), 64'(5));
    step(0, 1, 32'h0000_006F, 8'h30, 0, 0);
    step(0, 1, 32'h0000_0017, 8'h31, 0, 0);
    step(1, 0, 32'h0, 8'h00, 0, 0);
    chk("rstfull_vld", 64'(i32.out_valid), 64'(0));
    chk("rstfull_cnt", 64'(cnt32), 64'(0));
    step(0, 0, 32'h0, 8'h00, 0, 0);
    chk("post_rst_rdy", 64'(i32.in_ready), 64'(1));
    for (int n = 0; n < 800; n++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, rnd_ins(), 8'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    step(0, 0, 32'h0, 8'h00, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised RISC-V immediate generator with a valid/ready handshake.
- Decodes the immediate from a fetched instruction word and sign/zero-extends it to XLEN.
- Also reports the immediate format, flags illegal opcodes and counts them.
- Sits between fetch and decode in the pipelined core; a 2-entry skid buffer gives full throughput under backpressure.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried alongside each instruction (e.g. PC index).
- COUNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  instruction word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  format: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR.
- out_illegal  out  1  unrecognised opcode, or instr[1:0] != 2'b11.
- out_tag  out  TAG_W  tag of the result.
- cnt_clr  in  1  synchronous clear of illegal_count.
- illegal_count  out  COUNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset: all internal state cleared; state = EMPTY. While reset is high, in_ready = 0. After reset: out_valid = 0, out_imm = 0, out_type = 0, out_illegal = 0, out_tag = 0, illegal_count = 0.
- Decode (combinational on in_instr):
  - I-type: opcodes 0000011, 0010011, 1100111. imm = sext(instr[31:20]).
  - I-type, XLEN=64 only: 0000011/0010011 as above, plus 0011011 (OP-IMM-32). imm = sext(instr[31:20]).
  - S-type: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B-type: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J-type: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U-type: 0110111, 0010111. imm = sext({instr[31:12], 12'b0}); sign extends from bit 31 when XLEN=64.
  - NONE, legal: 0110011, 0001111, 1110011 (subject to the optional feature); 0111011 when XLEN=64. imm = 0.
  - Anything else: type NONE, imm 0, illegal = 1. instr[1:0] != 2'b11 is illegal regardless of opcode.
  - 0011011 and 0111011 are illegal when XLEN=32.
- Handshake:
  - Accept occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
  - Latency: 1 cycle from accept to out_valid.
  - Output registers hold stable while out_valid && !out_ready.
- Buffer state machine (main register + skid register):
  - EMPTY: accept -> ONE (decoded word into main).
  - ONE, accept only: -> FULL (new word into skid).
  - ONE, pop only: -> EMPTY.
  - ONE, accept and pop in the same cycle: stays ONE; main is loaded with the new word.
  - FULL: in_ready = 0. Pop -> ONE; skid moves to main, skid cleared.
  - in_ready = (state != FULL) && !reset.
  - Order is strictly preserved; no result is ever dropped or duplicated.
- illegal_count:
  - Increments at accept when the decoded illegal bit is 1.
  - Saturates at all-ones.
  - cnt_clr has priority over a same-cycle increment (result 0).
- Reset mid-operation: buffered entries are discarded, state = EMPTY, counter = 0.

Optional Feature:
- Macro: IMMGEN_CSR_UIMM_EN.
- Defined: opcode 1110011 with instr[14] = 1 gives type CSR, imm = zero-extended instr[19:15]. With instr[14] = 0, type NONE, imm 0.
- Not defined: opcode 1110011 is always type NONE, imm 0, legal; type code 6 is never produced.

Test Plan:
- XLEN=32, accept 0xFFC12083 (lw x1,-4(x2)), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFC, out_type=1, out_illegal=0.
- Stream 0x00512423 (sw, +8) then 0xFE000EE3 (beq, -4) on back-to-back cycles -> out_imm=0x00000008 type 2, then 0xFFFFFFFC type 3; one result per cycle, tags in order.
- XLEN=64, accept 0x800000B7 (lui x1,0x80000) -> out_imm=0xFFFFFFFF80000000, type 4.
- out_ready=0, present 3 words -> first two accepted, in_ready=0 on the third. Raise out_ready -> results emerge in order, third word accepted once in_ready returns to 1.
- Accept 0x00000000 three times, with cnt_clr pulsed in the same cycle as the third accept -> out_illegal=1 on each result; illegal_count 1, 2, then 0. With COUNT_W=2 and 5 illegal words (no clear) -> saturates at 3.
- Assert reset while FULL -> next cycle out_valid=0, illegal_count=0; in_ready=1 after reset deasserts.
